// File: rtl/axil_read_arbiter_if.sv
// AXI-Lite read-channel bundle; NUM_MASTERS lanes packed side by side.
// The master modport drives AR and R-ready, the slave modport answers them.
interface axil_read_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 1,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
);
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] araddr;
    logic [NUM_MASTERS*3-1:0]          arprot;
    logic [NUM_MASTERS-1:0]            arvalid;
    logic [NUM_MASTERS-1:0]            arready;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] rdata;
    logic [NUM_MASTERS*2-1:0]          rresp;
    logic [NUM_MASTERS-1:0]            rvalid;
    logic [NUM_MASTERS-1:0]            rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_read_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite read channel between NUM_MASTERS
// requesters; exactly one read is in flight at a time.
module axil_read_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axil_read_arbiter_if.slave   s_axil,
    axil_read_arbiter_if.master  m_axil
);
    localparam int unsigned GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                  state_q;
    logic [GW-1:0]           grant_q;
    logic [GW-1:0]           last_grant_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [2:0]              arprot_q;
    logic                    arvalid_q;

    logic [GW-1:0]           grant_d;
    logic                    found_d;
    logic [ADDR_WIDTH-1:0]   araddr_d;
    logic [2:0]              arprot_d;

    logic [NUM_MASTERS-1:0]  s_arready;
    logic [NUM_MASTERS-1:0]  s_rvalid;
    logic                    m_rready;
    logic [DATA_WIDTH-1:0]   rdata_fwd;
    logic [1:0]              rresp_fwd;
    logic                    ar_hs;
    logic                    r_hs;

    // Descending offsets let the smallest offset past last_grant win the scan.
    always_comb begin
        grant_d = '0;
        found_d = 1'b0;
        for (int unsigned off = NUM_MASTERS; off >= 1; off--) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (i == ((32'(last_grant_q) + off) % NUM_MASTERS) && s_axil.arvalid[i]) begin
                    grant_d = GW'(i);
                    found_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        araddr_d = '0;
        arprot_d = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (GW'(i) == grant_d) begin
                araddr_d = s_axil.araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                arprot_d = s_axil.arprot[i*3 +: 3];
            end
        end
    end

    // arready is held low while in reset so no handshake can be seen then.
    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (state_q == IDLE && aresetn && found_d && GW'(i) == grant_d) begin
                s_arready[i] = 1'b1;
            end
            if (state_q == DATA && GW'(i) == grant_q) begin
                s_rvalid[i] = m_axil.rvalid;
                m_rready    = s_axil.rready[i];
            end
        end
    end

    assign rdata_fwd = (state_q == DATA) ? m_axil.rdata : '0;
    assign rresp_fwd = (state_q == DATA) ? m_axil.rresp : '0;

    assign ar_hs = (state_q == IDLE) && found_d;
    assign r_hs  = (state_q == DATA) && m_axil.rvalid && m_rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_MASTERS - 1);
            araddr_q     <= '0;
            arprot_q     <= '0;
            arvalid_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        araddr_q  <= araddr_d;
                        arprot_q  <= arprot_d;
                        grant_q   <= grant_d;
                        arvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axil.arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign s_axil.arready = s_arready;
    assign s_axil.rvalid  = s_rvalid;
    assign s_axil.rdata   = {NUM_MASTERS{rdata_fwd}};
    assign s_axil.rresp   = {NUM_MASTERS{rresp_fwd}};

    assign m_axil.araddr  = araddr_q;
    assign m_axil.arprot  = arprot_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = m_rready;
endmodule
